// File: rtl/lsu_handshake.sv
// lsu_handshake: multi-cycle load/store unit sitting between EXE and a
// req/gnt/rvalid data-memory port. Accepts one op at a time, generates byte
// enables and lane-shifted store data, extracts and extends load data, and
// returns a one-cycle writeback response.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined     -> misaligned accesses return resp_err_o without touching memory
//   not defined -> misaligned addresses are silently aligned down to the size
module lsu_handshake #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic                lsu_we_i,
    input  logic [1:0]          lsu_size_i,
    input  logic                lsu_unsigned_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]     lsu_wdata_i,
    input  logic [4:0]          lsu_rd_i,
    output logic                resp_valid_o,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic [4:0]          resp_rd_o,
    output logic                resp_we_o,
    output logic                resp_err_o,
    output logic                stall_o,
    output logic                dmem_req_o,
    input  logic                dmem_gnt_i,
    output logic                dmem_we_o,
    output logic [XLEN/8-1:0]   dmem_be_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_rvalid_i,
    input  logic [XLEN-1:0]     dmem_rdata_i
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned LW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [31:0]     tmo_cnt;

    // Captured op attributes needed after the request phase
    logic            op_we;
    logic [1:0]      op_size;
    logic            op_uns;
    logic [LW-1:0]   op_lane;
    logic [4:0]      op_rd;

    // Decoded view of the incoming op
    logic [LW-1:0]   in_lane;
    logic [LW-1:0]   size_mask;
    logic [LW-1:0]   lane_eff;
    logic            size_illegal;
    logic            in_err;
    logic [2*NB-1:0] be_wide;
    logic [NB-1:0]   in_be;
    logic [XLEN-1:0] in_wdata;
    logic [ADDR_W-1:0] in_addr;

    // Load extraction
    logic [XLEN-1:0] shifted;
    logic [31:0]     nbits;
    logic            sign_bit;
    logic [XLEN-1:0] ld_ext;

    logic            busy;
    logic            tmo_hit;

    // Decode incoming op: lane, alignment/size legality, byte enables, store data
    always_comb begin
        in_lane      = lsu_addr_i[LW-1:0];
        size_mask    = LW'((32'd1 << lsu_size_i) - 32'd1);
        size_illegal = (32'd8 << lsu_size_i) > XLEN;
`ifdef LSU_MISALIGN_TRAP_EN
        lane_eff     = in_lane;
        in_err       = size_illegal | (|(in_lane & size_mask));
`else
        lane_eff     = in_lane & ~size_mask;
        in_err       = size_illegal;
`endif
        be_wide = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i < (32'd1 << lsu_size_i)) be_wide[i] = 1'b1;
        end
        be_wide  = be_wide << lane_eff;
        in_be    = be_wide[NB-1:0];
        in_wdata = lsu_wdata_i << {lane_eff, 3'b000};
        in_addr  = lsu_addr_i & ~ADDR_W'(NB - 1);
    end

    // Extract the addressed lane from read data and sign/zero-extend it
    always_comb begin
        shifted  = dmem_rdata_i >> {op_lane, 3'b000};
        nbits    = 32'd8 << op_size;
        sign_bit = 1'b0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i == nbits - 32'd1) sign_bit = shifted[i] & ~op_uns;
        end
        ld_ext = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            ld_ext[i] = (i < nbits) ? shifted[i] : sign_bit;
        end
    end

    // Timeout fires on the TIMEOUT-th consecutive cycle spent in REQ or WAIT
    always_comb begin
        tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TIMEOUT - 32'd1);
        busy    = (state != S_IDLE);
        stall_o = (lsu_valid_i & ~lsu_ready_o) | busy;
    end

    // Main handshake FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            lsu_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_rd_o    <= '0;
            resp_we_o    <= 1'b0;
            resp_err_o   <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= '0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            op_we        <= 1'b0;
            op_size      <= '0;
            op_uns       <= 1'b0;
            op_lane      <= '0;
            op_rd        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_valid_i) begin
                        op_we       <= lsu_we_i;
                        op_size     <= lsu_size_i;
                        op_uns      <= lsu_unsigned_i;
                        op_lane     <= lane_eff;
                        op_rd       <= lsu_rd_i;
                        lsu_ready_o <= 1'b0;
                        if (in_err) begin
                            state        <= S_RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_we_o    <= 1'b0;
                            resp_rdata_o <= '0;
                            resp_rd_o    <= lsu_rd_i;
                        end else begin
                            state        <= S_REQ;
                            tmo_cnt      <= '0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= lsu_we_i;
                            dmem_be_o    <= in_be;
                            dmem_addr_o  <= in_addr;
                            dmem_wdata_o <= in_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (op_we) begin
                            state        <= S_RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b0;
                            resp_we_o    <= 1'b0;
                            resp_rdata_o <= '0;
                            resp_rd_o    <= op_rd;
                        end else begin
                            state   <= S_WAIT;
                            tmo_cnt <= '0;
                        end
                    end else if (tmo_hit) begin
                        dmem_req_o   <= 1'b0;
                        state        <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_we_o    <= 1'b0;
                        resp_rdata_o <= '0;
                        resp_rd_o    <= op_rd;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        state        <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_we_o    <= 1'b1;
                        resp_rdata_o <= ld_ext;
                        resp_rd_o    <= op_rd;
                    end else if (tmo_hit) begin
                        state        <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_we_o    <= 1'b0;
                        resp_rdata_o <= '0;
                        resp_rd_o    <= op_rd;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_RESP: begin
                    state        <= S_IDLE;
                    lsu_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_we_o    <= 1'b0;
                    resp_rdata_o <= '0;
                end
                default: begin
                    state       <= S_IDLE;
                    lsu_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// Testbench for lsu_handshake: 32-bit instance (TIMEOUT=8) driven by directed
// and random ops checked against an arithmetic reference model; a 64-bit
// instance covers dword stores and upper-lane word loads.
module tb_lsu_handshake;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rstn;
    always #5 clk = ~clk;

    // 32-bit DUT signals
    logic        lsu_valid, lsu_ready, lsu_we, lsu_uns;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [4:0]  lsu_rd;
    logic        resp_valid, resp_we, resp_err, stall;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    // 64-bit DUT signals
    logic        w_valid, w_ready, w_we, w_uns;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [63:0] w_wdata;
    logic [4:0]  w_rd;
    logic        w_resp_valid, w_resp_we, w_resp_err, w_stall;
    logic [63:0] w_resp_rdata;
    logic [4:0]  w_resp_rd;
    logic        w_req, w_gnt, w_dwe, w_rvalid;
    logic [7:0]  w_be;
    logic [31:0] w_daddr;
    logic [63:0] w_dwdata, w_rdata;

    lsu_handshake #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_unsigned_i(lsu_uns), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_rd_i(lsu_rd),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_rd_o(resp_rd),
        .resp_we_o(resp_we), .resp_err_o(resp_err), .stall_o(stall),
        .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we),
        .dmem_be_o(dmem_be), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
    );

    lsu_handshake #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .rstn(rstn),
        .lsu_valid_i(w_valid), .lsu_ready_o(w_ready), .lsu_we_i(w_we),
        .lsu_size_i(w_size), .lsu_unsigned_i(w_uns), .lsu_addr_i(w_addr),
        .lsu_wdata_i(w_wdata), .lsu_rd_i(w_rd),
        .resp_valid_o(w_resp_valid), .resp_rdata_o(w_resp_rdata), .resp_rd_o(w_resp_rd),
        .resp_we_o(w_resp_we), .resp_err_o(w_resp_err), .stall_o(w_stall),
        .dmem_req_o(w_req), .dmem_gnt_i(w_gnt), .dmem_we_o(w_dwe),
        .dmem_be_o(w_be), .dmem_addr_o(w_daddr), .dmem_wdata_o(w_dwdata),
        .dmem_rvalid_i(w_rvalid), .dmem_rdata_i(w_rdata)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op on the 32-bit DUT with a memory agent that grants after gnt_dly
    // cycles and returns data rv_dly cycles after the grant.
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int unsigned gnt_dly,
                          input int unsigned rv_dly, input logic [31:0] mem);
        int unsigned    bytes, lane, elane;
        bit             err;
        longint unsigned v, lim, e_be, e_wd, e_ld;
        bytes = 32'd1 << size;
        lane  = addr % 4;
        err   = (bytes > 4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (lane % bytes != 0) err = 1'b1;
        elane = lane;
`else
        elane = lane - (lane % bytes);
`endif
        e_be = ((64'd1 << bytes) - 1) * (64'd1 << elane) % 16;
        e_wd = (64'(wdata) * (64'd1 << (8 * elane))) % (64'd1 << 32);
        lim  = 64'd1 << (8 * bytes);
        v    = (64'(mem) / (64'd1 << (8 * elane))) % lim;
        if (!uns && bytes < 4 && v >= lim / 2) v = v + (64'd1 << 32) - lim;
        e_ld = v;

        chk("ready_idle", lsu_ready, 1);
        chk("stall_idle", stall, 0);
        lsu_valid = 1'b1; lsu_we = we; lsu_size = size; lsu_uns = uns;
        lsu_addr = addr; lsu_wdata = wdata; lsu_rd = rd;
        tick();
        lsu_valid = 1'b0;
        if (err) begin
            chk("err_no_req", dmem_req, 0);
            chk("err_resp_valid", resp_valid, 1);
            chk("err_flag", resp_err, 1);
            chk("err_we", resp_we, 0);
            chk("err_rd", resp_rd, rd);
            tick();
            chk("err_ready_after", lsu_ready, 1);
            return;
        end
        for (int unsigned k = 0; k <= gnt_dly; k++) begin
            chk("req", dmem_req, 1);
            chk("req_no_resp", resp_valid, 0);
            chk("req_stall", stall, 1);
            chk("req_we", dmem_we, we);
            chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("req_be", dmem_be, e_be);
            if (we) chk("req_wdata", dmem_wdata, e_wd);
            if (k == gnt_dly) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        if (!we) begin
            for (int unsigned k = 0; k <= rv_dly; k++) begin
                chk("wait_no_req", dmem_req, 0);
                chk("wait_no_resp", resp_valid, 0);
                dmem_rdata = $urandom;
                if (k == rv_dly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = mem;
                end
                tick();
            end
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, 0);
        chk("resp_we", resp_we, !we);
        chk("resp_rd", resp_rd, rd);
        chk("resp_rdata", resp_rdata, we ? 64'd0 : e_ld);
        tick();
        chk("resp_one_cycle", resp_valid, 0);
        chk("ready_after", lsu_ready, 1);
    endtask

    // Load with gnt (or rvalid) withheld until the timeout fires
    task automatic run_timeout(input bit in_wait, input string tag);
        int unsigned cyc;
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_uns = 1'b0;
        lsu_addr = 32'h40; lsu_rd = 5'd9;
        tick();
        lsu_valid = 1'b0;
        if (in_wait) begin
            chk({tag, "_req"}, dmem_req, 1);
            dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
        end
        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 4 * TMO) begin
            cyc++;
            tick();
        end
        chk({tag, "_cycles"}, cyc, TMO);
        chk({tag, "_resp_valid"}, resp_valid, 1);
        chk({tag, "_err"}, resp_err, 1);
        chk({tag, "_we"}, resp_we, 0);
        chk({tag, "_req_dropped"}, dmem_req, 0);
        tick();
        chk({tag, "_ready"}, lsu_ready, 1);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk({tag, "_late_no_resp"}, resp_valid, 0);
        chk({tag, "_late_no_req"}, dmem_req, 0);
        chk({tag, "_late_ready"}, lsu_ready, 1);
    endtask

    initial begin
        rstn = 1'b0;
        lsu_valid = 0; lsu_we = 0; lsu_size = 0; lsu_uns = 0; lsu_addr = 0;
        lsu_wdata = 0; lsu_rd = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        w_valid = 0; w_we = 0; w_size = 0; w_uns = 0; w_addr = 0;
        w_wdata = 0; w_rd = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0;
        tick(); tick();

        // Reset state
        chk("rst_ready", lsu_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst64_ready", w_ready, 1);
        chk("rst64_req", w_req, 0);
        rstn = 1'b1;
        tick();

        // Directed examples
        run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd1, 0, 0, 32'h8000_00F0);
        run_op(1'b1, 2'b00, 1'b0, 32'h203, 32'hAB, 5'd2, 0, 0, 32'h0);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd3, 1, 2, 32'h8123_4567);
        run_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd4, 0, 1, 32'h8123_4567);
        run_op(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 5'd5, 0, 0, 32'h0);
        run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd6, 0, 0, 32'h0);
        run_op(1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 5'd7, 2, 0, 32'h80FF_FFFF);

        // Random ops
        for (int n = 0; n < 40; n++) begin
            run_op(1'($urandom), 2'($urandom_range(3, 0)), 1'($urandom), $urandom,
                   $urandom, 5'($urandom), $urandom_range(3, 0),
                   $urandom_range(3, 0), $urandom);
        end

        // Timeouts in REQ and WAIT, late responses ignored
        run_timeout(1'b0, "tmo_req");
        run_timeout(1'b1, "tmo_wait");

        // Reset while waiting for read data abandons the op
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h80; lsu_rd = 5'd10;
        tick();
        lsu_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rstw_in_wait", dmem_req, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rstw_ready", lsu_ready, 1);
        chk("rstw_no_resp", resp_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstw_late_no_resp", resp_valid, 0);
        chk("rstw_ready2", lsu_ready, 1);

        // 64-bit: SD to 0x10, then LW from lane 4
        w_valid = 1'b1; w_we = 1'b1; w_size = 2'b11; w_uns = 1'b0;
        w_addr = 32'h10; w_wdata = 64'h0123_4567_89AB_CDEF; w_rd = 5'd11;
        tick();
        w_valid = 1'b0;
        chk("x64_sd_req", w_req, 1);
        chk("x64_sd_be", w_be, 8'hFF);
        chk("x64_sd_addr", w_daddr, 32'h10);
        chk("x64_sd_wdata", w_dwdata, 64'h0123_4567_89AB_CDEF);
        w_gnt = 1'b1;
        tick();
        w_gnt = 1'b0;
        chk("x64_sd_resp", w_resp_valid, 1);
        chk("x64_sd_we", w_resp_we, 0);
        chk("x64_sd_rdata", w_resp_rdata, 0);
        tick();
        w_valid = 1'b1; w_we = 1'b0; w_size = 2'b10; w_uns = 1'b0;
        w_addr = 32'h14; w_rd = 5'd12;
        tick();
        w_valid = 1'b0;
        chk("x64_lw_be", w_be, 8'hF0);
        chk("x64_lw_addr", w_daddr, 32'h10);
        w_gnt = 1'b1;
        tick();
        w_gnt = 1'b0;
        w_rvalid = 1'b1; w_rdata = 64'h89AB_CDEF_0123_4567;
        tick();
        w_rvalid = 1'b0;
        chk("x64_lw_resp", w_resp_valid, 1);
        chk("x64_lw_rdata", w_resp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
        chk("x64_lw_we", w_resp_we, 1);
        chk("x64_lw_rd", w_resp_rd, 12);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
